// File: rtl/mm_operand_feeder.sv
// mm_operand_feeder: buffers one N x N A/B job from a row-major load stream,
// then streams A columns / B rows into a systolic matrix multiplier
// (N data steps followed by 2N-2 zero flush steps), waits for the product to
// be produced and drained, and clears the multiplier for the next job.
// All outputs are registered; they are computed from the next state so each
// output lines up with the state it belongs to.
// Optional feature: define MM_FEEDER_JOB_CNT_EN to build the 16-bit
// completed-job counter on job_count_o (otherwise job_count_o is tied to 0).
module mm_operand_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [DATA_WIDTH-1:0] load_a_i,
  input  logic [DATA_WIDTH-1:0] load_b_i,
  output logic                  mm_valid_o,
  output logic                  mm_reset_o,
  output logic [DATA_WIDTH-1:0] a_o [N],
  output logic [DATA_WIDTH-1:0] b_o [N],
  input  logic                  mm_done_i,
  input  logic                  drain_ack_i,
  output logic                  done_o,
  output logic [15:0]           job_count_o
);

  localparam int NN  = N * N;
  localparam int LCW = (NN > 1) ? $clog2(NN) : 1;
  localparam int SCW = $clog2(3 * N - 1);

  localparam logic [LCW-1:0] LCNT_LAST  = LCW'(NN - 1);
  localparam logic [LCW-1:0] LCNT_ONE   = LCW'(1);
  localparam logic [SCW-1:0] SCNT_LAST  = SCW'(3 * N - 3);
  localparam logic [SCW-1:0] SCNT_ONE   = SCW'(1);
  localparam logic [SCW-1:0] SCNT_FLUSH = SCW'(N);

  localparam logic [1:0] ST_LOAD      = 2'd0;
  localparam logic [1:0] ST_STREAM    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_CLEAR     = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LCW-1:0]        lcnt_q, lcnt_d;
  logic [SCW-1:0]        scnt_q, scnt_d;
  logic                  load_ready_q, load_ready_d;
  logic                  mm_valid_q, mm_valid_d;
  logic                  mm_reset_q, mm_reset_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] a_q [N];
  logic [DATA_WIDTH-1:0] a_d [N];
  logic [DATA_WIDTH-1:0] b_q [N];
  logic [DATA_WIDTH-1:0] b_d [N];

  // Operand buffers, row-major, intentionally without reset.
  logic [DATA_WIDTH-1:0] a_mem_q [NN];
  logic [DATA_WIDTH-1:0] b_mem_q [NN];

  logic                  load_fire_s;
  logic [LCW-1:0]        a_idx_s;
  logic [LCW-1:0]        b_idx_s;

  // Beat acceptance: only while LOAD is presenting ready.
  assign load_fire_s = load_valid_i && load_ready_q && (state_q == ST_LOAD);

  // Next-state, counters and the control outputs that follow the next state.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      ST_LOAD: begin
        if (load_fire_s) begin
          if (lcnt_q == LCNT_LAST) begin
            state_d = ST_STREAM;
            lcnt_d  = '0;
            scnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + LCNT_ONE;
          end
        end else begin
          lcnt_d = lcnt_q;
        end
      end
      ST_STREAM: begin
        if (scnt_q == SCNT_LAST) begin
          state_d = ST_WAIT_DONE;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCNT_ONE;
        end
      end
      ST_WAIT_DONE: begin
        // The drain ack only counts together with the multiplier's done.
        if (mm_done_i && drain_ack_i) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_LOAD;
        lcnt_d  = '0;
        scnt_d  = '0;
      end
      default: begin
        state_d = ST_LOAD;
        lcnt_d  = '0;
        scnt_d  = '0;
      end
    endcase
    load_ready_d = (state_d == ST_LOAD);
    mm_valid_d   = (state_d == ST_STREAM);
    mm_reset_d   = (state_d == ST_CLEAR);
    done_d       = (state_d == ST_CLEAR);
  end

  // Operand selection for the next step: A column s and B row s while s < N,
  // zeros otherwise. The final load beat is forwarded because it is written
  // on the same edge that launches step 0.
  always_comb begin
    a_idx_s = '0;
    b_idx_s = '0;
    for (int r = 0; r < N; r++) begin
      a_d[r] = '0;
      b_d[r] = '0;
    end
    if ((state_d == ST_STREAM) && (scnt_d < SCNT_FLUSH)) begin
      for (int r = 0; r < N; r++) begin
        a_idx_s = LCW'(r * N) + LCW'(scnt_d);
        b_idx_s = LCW'(int'(scnt_d) * N + r);
        if (load_fire_s && (a_idx_s == lcnt_q)) begin
          a_d[r] = load_a_i;
        end else begin
          a_d[r] = a_mem_q[a_idx_s];
        end
        if (load_fire_s && (b_idx_s == lcnt_q)) begin
          b_d[r] = load_b_i;
        end else begin
          b_d[r] = b_mem_q[b_idx_s];
        end
      end
    end else begin
      a_idx_s = '0;
      b_idx_s = '0;
    end
  end

  // State, counters and registered outputs; reset holds the multiplier in reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_LOAD;
      lcnt_q       <= '0;
      scnt_q       <= '0;
      load_ready_q <= 1'b0;
      mm_valid_q   <= 1'b0;
      mm_reset_q   <= 1'b1;
      done_q       <= 1'b0;
      for (int r = 0; r < N; r++) begin
        a_q[r] <= '0;
        b_q[r] <= '0;
      end
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      scnt_q       <= scnt_d;
      load_ready_q <= load_ready_d;
      mm_valid_q   <= mm_valid_d;
      mm_reset_q   <= mm_reset_d;
      done_q       <= done_d;
      for (int r = 0; r < N; r++) begin
        a_q[r] <= a_d[r];
        b_q[r] <= b_d[r];
      end
    end
  end

  // Operand buffer write on each accepted load beat.
  always_ff @(posedge clk_i) begin
    if (load_fire_s) begin
      a_mem_q[lcnt_q] <= load_a_i;
      b_mem_q[lcnt_q] <= load_b_i;
    end
  end

  assign load_ready_o = load_ready_q;
  assign mm_valid_o   = mm_valid_q;
  assign mm_reset_o   = mm_reset_q;
  assign done_o       = done_q;
  assign a_o          = a_q;
  assign b_o          = b_q;

`ifdef MM_FEEDER_JOB_CNT_EN
  logic [15:0] job_cnt_q, job_cnt_d;

  // Completed-job count; the new value appears together with done_o.
  always_comb begin
    if (state_d == ST_CLEAR) begin
      job_cnt_d = job_cnt_q + 16'd1;
    end else begin
      job_cnt_d = job_cnt_q;
    end
  end

  // Job counter register, wraps naturally at 16 bits.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      job_cnt_q <= 16'h0000;
    end else begin
      job_cnt_q <= job_cnt_d;
    end
  end

  assign job_count_o = job_cnt_q;
`else
  assign job_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_mm_operand_feeder.sv
// Testbench for mm_operand_feeder (N=4, DATA_WIDTH=8).
// Stimulus pushes the expected per-step operand vectors into a queue; a
// monitor pops and compares on every mm_valid_o cycle and accumulates the
// outer products to reconstruct the product C that a multiplier would form.
module tb_mm_operand_feeder;
  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int NN    = N * N;
  localparam int STEPS = 3 * N - 2;

  logic          clk = 1'b0;
  logic          reset_ni;
  logic          load_valid_i;
  logic          load_ready_o;
  logic [DW-1:0] load_a_i;
  logic [DW-1:0] load_b_i;
  logic          mm_valid_o;
  logic          mm_reset_o;
  logic [DW-1:0] a_o [N];
  logic [DW-1:0] b_o [N];
  logic          mm_done_i;
  logic          drain_ack_i;
  logic          done_o;
  logic [15:0]   job_count_o;

  int total = 0;
  int bad   = 0;
  logic [2*N*DW-1:0] exp_q [$];
  int a_m [NN];
  int b_m [NN];
  int c_exp [NN];
  int c_last [NN];
  int c_acc [NN];
  int done_cnt  = 0;
  int jobs_done = 0;

  mm_operand_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o),
    .load_a_i    (load_a_i),
    .load_b_i    (load_b_i),
    .mm_valid_o  (mm_valid_o),
    .mm_reset_o  (mm_reset_o),
    .a_o         (a_o),
    .b_o         (b_o),
    .mm_done_i   (mm_done_i),
    .drain_ack_i (drain_ack_i),
    .done_o      (done_o),
    .job_count_o (job_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*N*DW-1:0] ops_packed();
    logic [2*N*DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++) begin
      v[r*DW +: DW]     = a_o[r];
      v[(N+r)*DW +: DW] = b_o[r];
    end
    return v;
  endfunction

  function automatic int exp_jc();
`ifdef MM_FEEDER_JOB_CNT_EN
    return jobs_done & 32'h0000FFFF;
`else
    return 0;
`endif
  endfunction

  // Expected stream: step s<N carries A column s and B row s, then zeros.
  task automatic push_exp();
    logic [2*N*DW-1:0] v;
    for (int s = 0; s < STEPS; s++) begin
      v = '0;
      if (s < N) begin
        for (int r = 0; r < N; r++) begin
          v[r*DW +: DW]     = DW'(a_m[r*N+s]);
          v[(N+r)*DW +: DW] = DW'(b_m[s*N+r]);
        end
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic matmul();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_exp[i*N+j] = 0;
        for (int k = 0; k < N; k++) c_exp[i*N+j] += a_m[i*N+k] * b_m[k*N+j];
      end
  endtask

  // Monitor: scoreboard pop on valid cycles, zero check otherwise.
  initial begin : monitor
    int run_len;
    logic [2*N*DW-1:0] got;
    logic [2*N*DW-1:0] want;
    run_len = 0;
    forever begin
      @(negedge clk);
      got = ops_packed();
      if (!reset_ni) begin
        run_len = 0;
        for (int i = 0; i < NN; i++) c_acc[i] = 0;
      end else begin
        if (done_o) done_cnt++;
        if (mm_valid_o) begin
          run_len++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stream_pop: got an unexpected valid step %0h, expected none", got);
          end else begin
            want = exp_q.pop_front();
            chk("stream_ops", got, want);
          end
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              c_acc[r*N+c] += int'(a_o[r]) * int'(b_o[c]);
        end else begin
          chk("idle_ops_zero", got, 64'd0);
          if (run_len > 0) begin
            chk("stream_len", 64'(run_len), 64'(STEPS));
            c_last = c_acc;
            for (int i = 0; i < NN; i++) c_acc[i] = 0;
            run_len = 0;
          end
        end
      end
    end
  end

  task automatic reset_dut();
    reset_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_ctrl", {load_ready_o, mm_valid_o, done_o, mm_reset_o}, 64'b0001);
    chk("rst_ops_zero", ops_packed(), 64'd0);
    chk("rst_job_count", job_count_o, 64'd0);
    jobs_done = 0;
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    chk("rst_release_hold", {load_ready_o, mm_reset_o}, 64'b01);
    @(posedge clk); #1;
    chk("rst_first_edge", {load_ready_o, mm_reset_o}, 64'b10);
  endtask

  task automatic load_job(input bit toggle, input bit hold_after);
    int t;
    int cyc;
    t = 0;
    cyc = 0;
    push_exp();
    while (t < NN && cyc < 200) begin
      load_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
      load_a_i = DW'(a_m[t]);
      load_b_i = DW'(b_m[t]);
      @(negedge clk);
      if (load_valid_i && load_ready_o) t++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("load_beats", 64'(t), 64'(NN));
    chk("load_cycles", 64'(cyc), toggle ? 64'(2*NN-1) : 64'(NN));
    chk("stream_start", mm_valid_o, 64'd1);
    chk("ready_low_in_stream", load_ready_o, 64'd0);
    if (hold_after) begin
      load_valid_i = 1'b1;
      load_a_i = 8'hEE;
      load_b_i = 8'hEE;
    end else begin
      load_valid_i = 1'b0;
    end
  endtask

  task automatic finish_job(input int ack_delay, input bit ack_first);
    int cyc;
    cyc = 0;
    while (mm_valid_o === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("stream_end_bound", 64'(cyc < 100), 64'd1);
    #1;
    load_valid_i = 1'b0;
    for (int i = 0; i < NN; i++) chk("c_elem", 64'(c_last[i]), 64'(c_exp[i]));
    if (ack_first) begin
      drain_ack_i = 1'b1;
      mm_done_i = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("wait_ignores_lone_ack", {done_o, mm_reset_o, load_ready_o, mm_valid_o}, 64'd0);
      end
      drain_ack_i = 1'b0;
    end
    mm_done_i = 1'b1;
    repeat (ack_delay) begin
      @(negedge clk);
      chk("wait_hold", {done_o, mm_reset_o, load_ready_o, mm_valid_o}, 64'd0);
    end
    drain_ack_i = 1'b1;
    @(posedge clk); #1;
    chk("clear_done", done_o, 64'd1);
    chk("clear_mm_reset", mm_reset_o, 64'd1);
    jobs_done++;
    mm_done_i = 1'b0;
    drain_ack_i = 1'b0;
    @(posedge clk); #1;
    chk("post_clear", {done_o, mm_reset_o, load_ready_o, mm_valid_o}, 64'b0010);
    chk("job_count", job_count_o, 64'(exp_jc()));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int d0;
    reset_ni = 1'b1;
    load_valid_i = 1'b0;
    load_a_i = '0;
    load_b_i = '0;
    mm_done_i = 1'b0;
    drain_ack_i = 1'b0;
    #2;
    reset_dut();

    // Job 1: A = 1..16, B = identity, so C = A.
    for (int i = 0; i < NN; i++) begin
      a_m[i] = i + 1;
      b_m[i] = (i / N == i % N) ? 1 : 0;
      c_exp[i] = i + 1;
    end
    load_job(1'b0, 1'b0);
    finish_job(0, 1'b0);

    // Job 2: toggled load_valid, valid held high during stream, late ack.
    for (int i = 0; i < NN; i++) begin
      a_m[i] = (i * 7 + 3) % 256;
      b_m[i] = (i * 5 + 1) % 256;
    end
    matmul();
    load_job(1'b1, 1'b1);
    finish_job(5, 1'b1);

    // Job 3: reset at stream step 2 abandons the job.
    load_job(1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #3;
    chk("abort_in_stream", mm_valid_o, 64'd1);
    d0 = done_cnt;
    reset_dut();
    chk("no_done_on_abort", 64'(done_cnt), 64'(d0));

    // Jobs 4-6: all 0xFF, back to back; each C element 4*255*255 = 0x3F804.
    for (int i = 0; i < NN; i++) begin
      a_m[i] = 255;
      b_m[i] = 255;
      c_exp[i] = 32'h0003F804;
    end
    repeat (3) begin
      load_job(1'b0, 1'b0);
      finish_job(0, 1'b0);
    end

    // Job 7: reversed A against identity.
    for (int i = 0; i < NN; i++) begin
      a_m[i] = NN - i;
      b_m[i] = (i / N == i % N) ? 1 : 0;
      c_exp[i] = NN - i;
    end
    load_job(1'b0, 1'b0);
    finish_job(2, 1'b0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_operand_feeder.md
MM_OPERAND_FEEDER -- requirements
Module: mm_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default common_params::DATA_WIDTH (8): operand element width.
REQ-002 SHALL have parameter N, default common_params::N (4): matrix dimension.
REQ-003 SHALL have port clk_i, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port load_valid_i, input, 1: load beat valid.
REQ-006 SHALL have port load_ready_o, output, 1: feeder accepts a load beat.
REQ-007 SHALL have port load_a_i, input, DATA_WIDTH: A element, row-major order.
REQ-008 SHALL have port load_b_i, input, DATA_WIDTH: B element, row-major order.
REQ-009 SHALL have port mm_valid_o, output, 1: drives multiplier valid_i.
REQ-010 SHALL have port mm_reset_o, output, 1: drives multiplier reset_i (active-high, synchronous at the multiplier).
REQ-011 SHALL have port a_o[N], output, DATA_WIDTH each: drives multiplier a_i.
REQ-012 SHALL have port b_o[N], output, DATA_WIDTH each: drives multiplier b_i.
REQ-013 SHALL have port mm_done_i, input, 1: multiplier valid_o.
REQ-014 SHALL have port drain_ack_i, input, 1: downstream has captured c_o.
REQ-015 SHALL have port done_o, output, 1: one-cycle job-complete pulse.
REQ-016 SHALL have port job_count_o, output, 16: completed-job count (see Configuration).

Function
REQ-017 SHALL implement states LOAD, STREAM, WAIT_DONE and CLEAR.
REQ-018 LOAD: load_ready_o=1; each beat with load_valid_i&&load_ready_o SHALL store A[t/N][t%N] and B[t/N][t%N] from beat index t (0..N*N-1).
REQ-019 LOAD: the accepting edge of beat t=N*N-1 SHALL enter STREAM; load_valid_i SHALL be ignored outside LOAD.
REQ-020 STREAM: mm_valid_o SHALL be 1 for exactly 3N-2 consecutive cycles, with step counter s=0..3N-3.
REQ-021 STREAM, s<N: a_o[r]=A[r][s] and b_o[c]=B[s][c] for all r,c.
REQ-022 STREAM, s>=N: a_o and b_o SHALL be all zeros (flush cycles).
REQ-023 a_o and b_o SHALL be zero in every state other than STREAM.
REQ-024 After s=3N-3, the feeder SHALL enter WAIT_DONE with mm_valid_o=0.
REQ-025 WAIT_DONE: SHALL hold until mm_done_i && drain_ack_i are sampled high on the same edge, then enter CLEAR; drain_ack_i without mm_done_i SHALL be ignored.
REQ-026 CLEAR: lasts exactly one cycle, with mm_reset_o=1 and done_o=1, then returns to LOAD with load counter 0.
REQ-027 Buffer contents SHALL persist until overwritten by the next job's load beats.
REQ-028 Counters: load counter width $clog2(N*N); step counter width $clog2(3N-1); neither SHALL wrap inside a job.
REQ-029 Load latency: the first STREAM cycle SHALL be the cycle immediately after the final load beat is accepted.

Reset
REQ-030 Asserting reset_ni low SHALL immediately force: state LOAD, both counters 0, load_ready_o=0, mm_valid_o=0, done_o=0, a_o/b_o=0, mm_reset_o=1, job_count_o=0.
REQ-031 On the first clock edge after reset_ni rises: mm_reset_o=0 and load_ready_o=1.
REQ-032 Reset during STREAM or WAIT_DONE SHALL abandon the job with no done_o pulse, and SHALL hold the multiplier in reset via mm_reset_o.
REQ-033 Operand buffers are not reset; their contents are don't-care until reloaded.

Configuration
REQ-034 Macro MM_FEEDER_JOB_CNT_EN defined: job_count_o SHALL increment by 1 in each CLEAR cycle and wrap from 0xFFFF to 0.
REQ-035 Macro MM_FEEDER_JOB_CNT_EN undefined: job_count_o SHALL be constant 0 and no counter register is built.

Verification
REQ-036 N=4; load A=1..16 and B=identity, then hold drain_ack_i=1 -> step0 a_o={1,5,9,13}, b_o={1,0,0,0}; step3 a_o={4,8,12,16}, b_o={0,0,0,1}; multiplier c_o=1..16.
REQ-037 N=4; load_valid_i toggled 1,0,1,0 -> exactly 16 accepted beats; STREAM starts the cycle after the 16th beat; mm_valid_o high for 10 cycles.
REQ-038 N=4; job done with drain_ack_i=0 for 5 cycles, then 1 -> WAIT_DONE holds, mm_reset_o=0, done_o=0 until the ack; then one cycle with mm_reset_o=1 and done_o=1.
REQ-039 N=4; reset_ni pulsed low at STREAM s=2 -> all outputs take reset values asynchronously; no done_o; the next clean job produces correct c_o.
REQ-040 N=4; all-0xFF operands, 3 back-to-back jobs -> each c_o element=0x3F804 (18-bit); with MM_FEEDER_JOB_CNT_EN, job_count_o=1,2,3; without it, job_count_o stays 0.
